path_replayer: RTL and testbench
================================

Name: path_replayer

Overview:
- Sits directly downstream of the maze-solving rat datapath/controller and consumes the move stream it produces while searching.
- Records forward steps, discards backtracked steps, and freezes the surviving start-to-cheese path when the solver reports Done.
- On Run, it replays that path one move per accepted handshake and tracks the replayed X,Y position for display/animation logic.

Parameters:
DEPTH, 64, maximum number of path moves stored (power of two, >= 2)
START_X, 4'd0, X coordinate loaded at the start of every replay
START_Y, 4'd0, Y coordinate loaded at the start of every replay

Ports:
CLK  input  1  clock, all state updates on rising edge
RST  input  1  synchronous, active-high reset
Start  input  1  new solve begins; clears buffer, enters RECORD
MoveIn  input  2  move code from solver (00 up Y-1, 01 right X+1, 10 left X-1, 11 down Y+1)
MoveWr  input  1  solver committed a forward step with MoveIn
MoveUndo  input  1  solver backtracked; drop last stored move
Done  input  1  solver reached goal
Fail  input  1  solver exhausted maze
Run  input  1  request replay
Ready  input  1  consumer accepts current replay move
Move  output  2  replayed move code
Valid  output  1  Move is valid this cycle
X  output  4  replay X position (after all accepted moves)
Y  output  4  replay Y position
Busy  output  1  high in REPLAY
Finished  output  1  high in FINISHED
Failed  output  1  high in FAILED
Overflow  output  1  sticky: MoveWr arrived with buffer full
Count  output  $clog2(DEPTH)+1  number of stored moves

Behaviour:
- Reset: state IDLE, Count=0, read pointer=0, Move=00, Valid=0, X=START_X, Y=START_Y, Busy/Finished/Failed/Overflow=0.
- States: IDLE, RECORD, READY, REPLAY, FINISHED, FAILED. Start in any state takes priority: Count:=0, Overflow:=0, X/Y:=START, next state RECORD.
- RECORD: buffer is a LIFO indexed by Count.
  - MoveWr only: if Count<DEPTH, mem[Count]:=MoveIn and Count+1; else drop the move and set Overflow.
  - MoveUndo only: if Count>0, Count-1; else ignore.
  - MoveWr and MoveUndo in the same cycle: overwrite mem[Count-1] with MoveIn, Count unchanged. If Count=0, treat as MoveWr only.
  - Done: go to READY. If Done coincides with MoveWr/MoveUndo, apply the buffer update first. Done and Fail together resolve as Fail.
  - Fail: go to FAILED, Count:=0.
- READY: Run starts the replay: read pointer:=0, X:=START_X, Y:=START_Y, go to REPLAY. If Count=0, go directly to FINISHED.
- REPLAY: Valid=1 and Move=mem[read pointer], both combinational from state/pointer.
  - On Valid&Ready: update X/Y by the move code, with modulo-16 wrap (0-1=15, 15+1=0). Increment the pointer.
  - When the pointer reaches Count, go to FINISHED the same edge.
  - Move/Valid must hold stable while Ready=0.
- FINISHED: Valid=0; X/Y hold the final position. Run re-enters REPLAY with pointer/X/Y reset to start.
- FAILED: Valid=0; Run ignored; only Start or RST leaves.
- Run is ignored in IDLE, RECORD, and REPLAY. MoveWr/MoveUndo/Done/Fail are ignored outside RECORD.
- RST mid-replay: all outputs return to reset values on that edge. Buffer contents are don't-care.
- Latency: first Valid is on the cycle after the Run edge. Throughput is one move per cycle with Ready held high.

Test Plan:
- Start; MoveWr 01,01,11; Done; Run with Ready=1 -> Valid for 3 cycles, Move 01,01,11; X/Y end at (2,1); Finished=1; Count=3.
- Start; MoveWr 01,11,01; MoveUndo; MoveWr 11; Done; Run -> replayed moves 01,11,11; final (1,2).
- Same-cycle MoveWr=10 with MoveUndo at Count=2 -> Count stays 2, second move becomes 10; replay shows 01,10.
- Replay 3 moves with Ready toggling 1,0,0,1,1 -> Move/Valid hold while Ready=0; exactly 3 handshakes; Finished after the 5th cycle.
- DEPTH=4: five MoveWr -> Count=4, Overflow=1; Start clears Overflow. Also from (0,0), move 00 gives Y=15 (wrap check).
- Fail during RECORD -> Failed=1, Count=0, Run ignored. RST asserted mid-REPLAY -> state IDLE, X=0, Y=0, Valid=0 on the next edge.

Source files
------------

// File: rtl/path_replayer.sv
// path_replayer: records the rat solver's forward moves in a LIFO. Backtracked
// moves are dropped. On Done the surviving path is frozen, and on Run it is
// replayed one move per Valid/Ready handshake while the X,Y position is tracked.
module path_replayer #(
   parameter int unsigned DEPTH   = 64,
   parameter logic [3:0]  START_X = 4'd0,
   parameter logic [3:0]  START_Y = 4'd0
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       Start,
   input  logic [1:0]                 MoveIn,
   input  logic                       MoveWr,
   input  logic                       MoveUndo,
   input  logic                       Done,
   input  logic                       Fail,
   input  logic                       Run,
   input  logic                       Ready,
   output logic [1:0]                 Move,
   output logic                       Valid,
   output logic [3:0]                 X,
   output logic [3:0]                 Y,
   output logic                       Busy,
   output logic                       Finished,
   output logic                       Failed,
   output logic                       Overflow,
   output logic [$clog2(DEPTH):0]     Count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RECORD,
      S_READY,
      S_REPLAY,
      S_FINISHED,
      S_FAILED
   } state_t;

   state_t        state;
   logic [1:0]    mem [DEPTH];
   logic [CW-1:0] count;
   logic [CW-1:0] cnt_m1;
   logic [CW-1:0] rd_ptr;
   logic [CW-1:0] rd_ptr_p1;
   logic          overflow;
   logic [3:0]    x, y;
   logic [3:0]    nx, ny;
   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic          has_moves;
   logic          full;

   assign cnt_m1    = count - CW'(1);
   assign rd_ptr_p1 = rd_ptr + CW'(1);
   assign has_moves = (count != '0);
   assign full      = (count >= CW'(DEPTH));

   // Buffer write decode: a write paired with an undo replaces the top entry
   // in place; at Count=0 the pair degrades to a plain push.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = '0;
      if (state == S_RECORD && !Start && MoveWr) begin
         if (MoveUndo && has_moves) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_m1[AW-1:0];
         end else if (!full) begin
            mem_we    = 1'b1;
            mem_waddr = count[AW-1:0];
         end
      end
   end

   // Move storage has no reset: its contents are meaningless until recorded.
   always_ff @(posedge CLK) begin
      if (mem_we)
         mem[mem_waddr] <= MoveIn;
   end

   // Replay move and handshake valid, taken straight from the state and the
   // pointer so they hold steady while Ready is low.
   always_comb begin
      Valid = (state == S_REPLAY);
      Move  = Valid ? mem[rd_ptr[AW-1:0]] : 2'b00;
   end

   // Position after applying the current move, with modulo-16 wrap.
   always_comb begin
      nx = x;
      ny = y;
      case (Move)
         2'b00:   ny = y - 4'd1;
         2'b01:   nx = x + 4'd1;
         2'b10:   nx = x - 4'd1;
         default: ny = y + 4'd1;
      endcase
   end

   // Main controller: recording, replay sequencing and position tracking.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= S_IDLE;
         count    <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
         x        <= START_X;
         y        <= START_Y;
      end else if (Start) begin
         state    <= S_RECORD;
         count    <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
         x        <= START_X;
         y        <= START_Y;
      end else begin
         case (state)
            S_RECORD: begin
               if (MoveWr && !(MoveUndo && has_moves)) begin
                  if (!full)
                     count <= count + CW'(1);
                  else
                     overflow <= 1'b1;
               end else if (!MoveWr && MoveUndo && has_moves) begin
                  count <= cnt_m1;
               end
               // Fail wins over Done and also discards the recorded path.
               if (Fail) begin
                  state <= S_FAILED;
                  count <= '0;
               end else if (Done) begin
                  state <= S_READY;
               end
            end
            S_READY, S_FINISHED: begin
               if (Run) begin
                  rd_ptr <= '0;
                  x      <= START_X;
                  y      <= START_Y;
                  state  <= has_moves ? S_REPLAY : S_FINISHED;
               end
            end
            S_REPLAY: begin
               if (Ready) begin
                  x      <= nx;
                  y      <= ny;
                  rd_ptr <= rd_ptr_p1;
                  if (rd_ptr_p1 == count)
                     state <= S_FINISHED;
               end
            end
            default: ;
         endcase
      end
   end

   // Status outputs decoded from registered state.
   always_comb begin
      Busy     = (state == S_REPLAY);
      Finished = (state == S_FINISHED);
      Failed   = (state == S_FAILED);
      Overflow = overflow;
      Count    = count;
      X        = x;
      Y        = y;
   end

endmodule

// File: tb/tb_path_replayer.sv
// tb_path_replayer: directed stimulus with a scoreboard of expected replay moves
// that is drained by an independent monitor on each Valid&Ready handshake.
module tb_path_replayer;

   logic       clk = 1'b0;
   logic       rst, start, move_wr, move_undo, done, fail, run, ready;
   logic [1:0] move_in;

   logic [1:0] move, d4_move;
   logic       valid, busy, finished, failed, overflow;
   logic       d4_valid, d4_busy, d4_finished, d4_failed, d4_overflow;
   logic [3:0] x, y, d4_x, d4_y;
   logic [6:0] count;
   logic [2:0] d4_count;

   int vecs = 0;
   int errs = 0;
   logic [1:0] exp_q [$];

   always #5 clk = ~clk;

   path_replayer #(.DEPTH(64), .START_X(4'd0), .START_Y(4'd0)) u_dut (
      .CLK(clk), .RST(rst), .Start(start), .MoveIn(move_in), .MoveWr(move_wr),
      .MoveUndo(move_undo), .Done(done), .Fail(fail), .Run(run), .Ready(ready),
      .Move(move), .Valid(valid), .X(x), .Y(y), .Busy(busy), .Finished(finished),
      .Failed(failed), .Overflow(overflow), .Count(count)
   );

   path_replayer #(.DEPTH(4), .START_X(4'd0), .START_Y(4'd0)) u_d4 (
      .CLK(clk), .RST(rst), .Start(start), .MoveIn(move_in), .MoveWr(move_wr),
      .MoveUndo(move_undo), .Done(done), .Fail(fail), .Run(run), .Ready(ready),
      .Move(d4_move), .Valid(d4_valid), .X(d4_x), .Y(d4_y), .Busy(d4_busy),
      .Finished(d4_finished), .Failed(d4_failed), .Overflow(d4_overflow),
      .Count(d4_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every accepted replay move is compared against the scoreboard.
   always @(negedge clk) begin
      if (valid === 1'b1 && ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            vecs++;
            errs++;
            $display("FAIL unexpected_move: got %0d, expected none", move);
         end else begin
            chk("replay_move", {30'd0, move}, {30'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1; cyc(); start = 1'b0;
   endtask

   task automatic do_wr(input logic [1:0] m);
      move_in = m; move_wr = 1'b1; cyc(); move_wr = 1'b0;
   endtask

   task automatic do_undo();
      move_undo = 1'b1; cyc(); move_undo = 1'b0;
   endtask

   task automatic do_done();
      done = 1'b1; cyc(); done = 1'b0;
   endtask

   // Run with Ready held high until Finished, bounded by a cycle budget.
   task automatic replay_all(input string tag);
      int k;
      run = 1'b1; cyc(); run = 1'b0;
      chk({tag, "_first_valid"}, {31'd0, valid}, 32'd1);
      ready = 1'b1;
      k = 0;
      while (finished !== 1'b1 && k < 100) begin
         cyc();
         k++;
      end
      ready = 1'b0;
      chk({tag, "_finished"}, {31'd0, finished}, 32'd1);
      chk({tag, "_sb_drained"}, exp_q.size(), 32'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; move_in = 2'b00; move_wr = 1'b0; move_undo = 1'b0;
      done = 1'b0; fail = 1'b0; run = 1'b0; ready = 1'b0;
      repeat (3) cyc();
      rst = 1'b0;
      cyc();

      // Reset state
      chk("rst_count", {25'd0, count}, 32'd0);
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_move", {30'd0, move}, 32'd0);
      chk("rst_xy", {24'd0, x, y}, 32'h00);
      chk("rst_flags", {28'd0, busy, finished, failed, overflow}, 32'd0);

      // Run in IDLE is ignored
      run = 1'b1; cyc(); run = 1'b0;
      chk("idle_run_busy", {31'd0, busy}, 32'd0);

      // Straight path 01,01,11 -> (2,1)
      do_start();
      do_wr(2'b01); do_wr(2'b01); do_wr(2'b11);
      do_done();
      exp_q.push_back(2'b01); exp_q.push_back(2'b01); exp_q.push_back(2'b11);
      replay_all("t1");
      chk("t1_xy", {24'd0, x, y}, 32'h21);
      chk("t1_count", {25'd0, count}, 32'd3);

      // Backtrack: 01,11,01, undo, 11 -> 01,11,11 -> (1,2)
      do_start();
      do_wr(2'b01); do_wr(2'b11); do_wr(2'b01);
      do_undo();
      do_wr(2'b11);
      do_done();
      exp_q.push_back(2'b01); exp_q.push_back(2'b11); exp_q.push_back(2'b11);
      replay_all("t2");
      chk("t2_xy", {24'd0, x, y}, 32'h12);

      // Same-cycle write+undo replaces the top entry
      do_start();
      do_wr(2'b01); do_wr(2'b11);
      move_in = 2'b10; move_wr = 1'b1; move_undo = 1'b1; cyc();
      move_wr = 1'b0; move_undo = 1'b0;
      chk("t3_count", {25'd0, count}, 32'd2);
      do_done();
      exp_q.push_back(2'b01); exp_q.push_back(2'b10);
      replay_all("t3");
      chk("t3_xy", {24'd0, x, y}, 32'h00);

      // Ready pattern 1,0,0,1,1 over moves 11,01,00
      do_start();
      do_wr(2'b11); do_wr(2'b01); do_wr(2'b00);
      do_done();
      exp_q.push_back(2'b11); exp_q.push_back(2'b01); exp_q.push_back(2'b00);
      run = 1'b1; cyc(); run = 1'b0;
      ready = 1'b1;
      chk("t4_c1_move", {29'd0, valid, move}, {29'd0, 1'b1, 2'b11});
      cyc();
      ready = 1'b0;
      chk("t4_c2_hold", {29'd0, valid, move}, {29'd0, 1'b1, 2'b01});
      cyc();
      chk("t4_c3_hold", {29'd0, valid, move}, {29'd0, 1'b1, 2'b01});
      cyc();
      ready = 1'b1;
      chk("t4_c4_move", {29'd0, valid, move}, {29'd0, 1'b1, 2'b01});
      cyc();
      chk("t4_c5_move", {29'd0, valid, move}, {29'd0, 1'b1, 2'b00});
      chk("t4_c5_not_fin", {31'd0, finished}, 32'd0);
      cyc();
      ready = 1'b0;
      chk("t4_finished", {31'd0, finished}, 32'd1);
      chk("t4_sb_drained", exp_q.size(), 32'd0);
      chk("t4_xy", {24'd0, x, y}, 32'h10);

      // Capacity limit on the DEPTH=4 instance, plus undo at Count=0
      do_start();
      do_undo();
      chk("undo_at_zero", {25'd0, count}, 32'd0);
      repeat (5) do_wr(2'b01);
      chk("d4_count_full", {29'd0, d4_count}, 32'd4);
      chk("d4_overflow", {31'd0, d4_overflow}, 32'd1);
      chk("d64_count", {25'd0, count}, 32'd5);
      chk("d64_no_overflow", {31'd0, overflow}, 32'd0);
      do_start();
      chk("d4_overflow_clr", {31'd0, d4_overflow}, 32'd0);
      chk("d4_count_clr", {29'd0, d4_count}, 32'd0);

      // Wrap: move up from (0,0) lands at Y=15
      do_wr(2'b00);
      do_done();
      exp_q.push_back(2'b00);
      replay_all("wrap");
      chk("wrap_xy", {24'd0, x, y}, 32'h0F);

      // Fail during RECORD; Run ignored afterwards
      do_start();
      do_wr(2'b01);
      fail = 1'b1; done = 1'b1; cyc(); fail = 1'b0; done = 1'b0;
      chk("fail_flag", {31'd0, failed}, 32'd1);
      chk("fail_count", {25'd0, count}, 32'd0);
      run = 1'b1; cyc(); run = 1'b0;
      chk("fail_run_ignored", {30'd0, failed, valid}, 32'd2);

      // RST in the middle of a replay
      do_start();
      do_wr(2'b01); do_wr(2'b01); do_wr(2'b01);
      do_done();
      exp_q.push_back(2'b01); exp_q.push_back(2'b01); exp_q.push_back(2'b01);
      run = 1'b1; cyc(); run = 1'b0;
      ready = 1'b1;
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0; ready = 1'b0;
      exp_q.delete();
      chk("rst_mid_valid", {31'd0, valid}, 32'd0);
      chk("rst_mid_xy", {24'd0, x, y}, 32'h00);
      chk("rst_mid_busy", {31'd0, busy}, 32'd0);
      chk("rst_mid_count", {25'd0, count}, 32'd0);

      cyc();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
